// File: rtl/prog_clock_divider_if.sv
// Control/status bundle for prog_clock_divider: run request, divisor load
// strobe and the divided-clock outputs.
interface prog_clock_divider_if #(
  parameter int DIV_WIDTH = 24
);
  logic                 en;
  logic [DIV_WIDTH-1:0] div;
  logic                 div_load;
  logic                 out_clk;
  logic                 tick;
  logic                 div_ack;
  logic                 running;

  modport master (output en, div, div_load, input out_clk, tick, div_ack, running);
  modport slave  (input en, div, div_load, output out_clk, tick, div_ack, running);
endinterface

// File: rtl/prog_clock_divider.sv
// Runtime-programmable synchronous clock divider. Divisor changes and start/stop
// only take effect at period boundaries, so out_clk never glitches.
module prog_clock_divider #(
  parameter int DIV_WIDTH   = 24,
  parameter int DEFAULT_DIV = 1_000_000
) (
  input logic                 clk,
  input logic                 rst,
  prog_clock_divider_if.slave bus
);
  typedef logic [DIV_WIDTH-1:0] div_t;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  localparam div_t ONE       = div_t'(1);
  localparam div_t TWO       = div_t'(2);
  localparam div_t RESET_DIV = (div_t'(DEFAULT_DIV) < TWO) ? TWO : div_t'(DEFAULT_DIV);

  state_t state;
  div_t   cnt;
  div_t   active_n;
  div_t   pending_n;
  div_t   next_n;
  logic   pending_valid;
  logic   apply;
  logic   period_end;
  logic   out_clk_q;
  logic   tick_q;
  logic   div_ack_q;

  function automatic div_t clamp_div(input div_t n);
    return (n < TWO) ? TWO : n;
  endfunction

  // ceil(N/2) without needing a carry bit beyond DIV_WIDTH.
  function automatic div_t high_len(input div_t n);
    return (n >> 1) + div_t'(n[0]);
  endfunction

  // A strobe arriving in the boundary cycle bypasses the pending register.
  assign next_n     = bus.div_load ? clamp_div(bus.div) : pending_n;
  assign apply      = bus.div_load | pending_valid;
  assign period_end = (state == IDLE) || (cnt == active_n - ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      active_n      <= RESET_DIV;
      pending_n     <= '0;
      pending_valid <= 1'b0;
      out_clk_q     <= 1'b0;
      tick_q        <= 1'b0;
      div_ack_q     <= 1'b0;
    end else begin
      tick_q    <= 1'b0;
      div_ack_q <= 1'b0;
      if (bus.div_load) begin
        pending_n     <= clamp_div(bus.div);
        pending_valid <= 1'b1;
      end
      if (period_end) begin
        cnt <= '0;
        if (apply) begin
          active_n      <= next_n;
          // NOTE: non-blocking, so this clear overrides the set above in the
          // same cycle; next_n already carries any same-cycle strobe.
          pending_valid <= 1'b0;
          div_ack_q     <= 1'b1;
        end
        state     <= bus.en ? RUN : IDLE;
        out_clk_q <= bus.en;
        tick_q    <= bus.en;
      end else begin
        cnt       <= cnt + ONE;
        out_clk_q <= (cnt + ONE) < high_len(active_n);
        state     <= bus.en ? RUN : STOPPING;
      end
    end
  end

  assign bus.out_clk = out_clk_q;
  assign bus.tick    = tick_q;
  assign bus.div_ack = div_ack_q;
  assign bus.running = (state != IDLE);
endmodule
